// File: rtl/jam_pkg.sv
// Shared constants and arbiter state type for the job-assignment search engines.
package jam_pkg;
  localparam int DEF_AW      = 3;
  localparam int DEF_CW      = 7;
  localparam int JAM_WORKERS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// With ARB_FIXED_PRIO_EN defined the search always starts at requester 0.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] start;

`ifdef ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  assign start = ptr;
`endif

  always_comb begin
    int            c;
    logic          found;
    logic [IW-1:0] ci;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(start) + k;
      if (c >= NREQ) c = c - NREQ;
      ci = IW'(c);
      if (!found && req[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end
endmodule

// File: rtl/cost_rom_arbiter.sv
// Burst-granular arbiter sharing one async-read cost ROM among NREQ search engines.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module cost_rom_arbiter
  import jam_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int BURST_LEN = 8,
  parameter int AW        = DEF_AW,
  parameter int CW        = DEF_CW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_w,
  input  logic [NREQ*AW-1:0] req_j,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     W,
  output logic [AW-1:0]     J,
  input  logic [CW-1:0]     Cost,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [CW-1:0]     rsp_cost,
  output logic              busy,
  output logic              lock_err
);
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(BURST_LEN + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(BURST_LEN);

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + 1'b1;
  endfunction

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]   rr_ptr, rr_d;
  logic            lock_err_d;
  logic [NREQ-1:0] rsp_owner;
  logic [NREQ-1:0] pick_gnt, owner_oh;
  logic [IW-1:0]   pick_idx, sel;
  logic            accept;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  // gnt is forced low while reset is asserted so no beat appears accepted.
  always_comb begin
    gnt = '0;
    if (RST) gnt = (state_q == LOCK) ? (owner_oh & req) : pick_gnt;
  end

  assign accept = |(gnt & req);
  assign sel    = (state_q == LOCK) ? owner_q : pick_idx;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    rr_d       = rr_ptr;
    lock_err_d = 1'b0;
    cnt_inc    = cnt_q + 1'b1;
    if (accept) begin
      if (state_q == IDLE) begin
        if (req_last[sel] || BURST_LEN <= 1) begin
          rr_d       = next_idx(sel);
          lock_err_d = !req_last[sel];
        end else begin
          state_d = LOCK;
          owner_d = sel;
          cnt_d   = CNTW'(1);
        end
      end else begin
        // A burst closes on its last beat or is cut off once it reaches BURST_LEN beats.
        if (req_last[sel] || cnt_inc >= CNT_MAX) begin
          state_d    = IDLE;
          cnt_d      = '0;
          rr_d       = next_idx(owner_q);
          lock_err_d = !req_last[sel];
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      cnt_q     <= '0;
      lock_err  <= 1'b0;
      W         <= '0;
      J         <= '0;
      rsp_owner <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      lock_err <= lock_err_d;
      if (accept) begin
        W         <= req_w[sel*AW +: AW];
        J         <= req_j[sel*AW +: AW];
        rsp_owner <= gnt;
      end else begin
        rsp_owner <= '0;
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rr_ptr <= '0;
    else      rr_ptr <= rr_d;
  end
`endif

  assign busy      = (state_q == LOCK);
  assign rsp_valid = rsp_owner;
  assign rsp_cost  = Cost;
endmodule

// File: doc/cost_rom_arbiter.md
Name: cost_rom_arbiter

Overview:
- Shares the single asynchronous-read cost ROM (W/J address in, 7-bit Cost out) among NREQ job-assignment search engines.
- Each engine evaluates one permutation by issuing a burst of up to BURST_LEN reads, one per worker.
- The arbiter grants whole bursts, arbitrates round-robin between bursts and routes each returned Cost to its owner.

Parameters:
- NREQ, 2, number of requesting engines (2..8)
- BURST_LEN, 8, maximum beats per burst; a burst is force-closed after this many beats
- AW, 3, width of the worker index and of the job index
- CW, 7, cost data width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester beat request, held until granted
- req_w  in  NREQ*AW  per-requester worker index, slice i = bits [i*AW +: AW]
- req_j  in  NREQ*AW  per-requester job index, same slicing
- req_last  in  NREQ  marks the final beat of the current burst
- gnt  out  NREQ  one-hot beat accept; combinational
- W  out  AW  ROM worker address; registered
- J  out  AW  ROM job address; registered
- Cost  in  CW  ROM read data, valid in the same cycle W/J are presented
- rsp_valid  out  NREQ  one-hot; Cost belongs to requester i this cycle
- rsp_cost  out  CW  equals Cost (shared bus)
- busy  out  1  high while a burst is owned (state LOCK)
- lock_err  out  1  single-cycle pulse when a burst is force-closed

Behaviour:
- States: IDLE and LOCK. Registers: owner index, rr_ptr, beat_cnt (width clog2(BURST_LEN+1)), rsp_owner (one-hot).
- Beat acceptance: a beat is accepted in cycle t when gnt[i] & req[i] are both high. A requester must hold req, req_w, req_j and req_last stable until its beat is accepted.
- IDLE: gnt goes to the first requester with req high, searching from rr_ptr upward and wrapping. No grant is issued when req is 0.
  - Accept with req_last=1: stay in IDLE.
  - Accept with req_last=0: go to LOCK with owner=i and beat_cnt=1.
- LOCK: gnt[owner] = req[owner]; all other gnt bits are 0. Each accepted beat increments beat_cnt.
  - Accept with req_last=1: go to IDLE.
  - Accept with req_last=0 while beat_cnt reaches BURST_LEN: go to IDLE and pulse lock_err for 1 cycle.
- rr_ptr: updated to owner+1 (mod NREQ) when a burst closes, whether normally or forced. A single-beat burst in IDLE updates rr_ptr to i+1 immediately.
- No dead cycle between bursts: the next burst's first beat can be accepted in the cycle after the previous last beat.
- Address path: on an accepted beat at cycle t, W and J are registered from req_w/req_j[owner] and are visible in cycle t+1. rsp_owner is set to one-hot(i) at the same edge. With no accept, rsp_owner is cleared to 0 and W/J hold their values.
- Response: rsp_valid = rsp_owner and rsp_cost = Cost, both combinational. Response latency is exactly 1 cycle after accept.
- An owner that drops req mid-burst keeps the lock; no timeout is applied.
- Reset values (RST low, asynchronous):
  - State IDLE, owner 0, rr_ptr 0, beat_cnt 0, rsp_owner 0.
  - W 0, J 0, busy 0, lock_err 0, gnt 0.
  - A burst in flight at reset is discarded and no response is generated.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: the IDLE search always starts at requester 0, making requester 0 highest priority. rr_ptr is removed; lock and burst behaviour are unchanged.
- Not defined: round-robin arbitration as described above.

Decomposition:
- Package jam_pkg holds:
  - AW and CW defaults
  - JAM_WORKERS = 8
  - the arbiter state enum {IDLE, LOCK}
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs one-hot grant and index. Its search start is forced to 0 under ARB_FIXED_PRIO_EN.

Test Plan:
- Single requester 0, 8-beat burst with W=0..7, J=7..0, ROM Cost=W+J:
  - Expected: gnt[0] high for 8 consecutive cycles; W/J lag gnt by 1; rsp_valid[0] for 8 cycles with rsp_cost=7 each; busy high for beats 2..8; lock_err stays 0.
- Requesters 0 and 1 both request continuously, 8-beat bursts each:
  - Expected: bursts alternate 0,1,0,1 with no idle cycle between them; beats from the two requesters never interleave.
- Requester 1 drops req for 3 cycles mid-burst while requester 0 requests:
  - Expected: gnt[0] stays 0; requester 1 resumes and finishes its burst; requester 0 is then granted.
- Requester 0 sends 8 beats with no req_last:
  - Expected: after beat 8, lock_err pulses once and state returns to IDLE; requester 1 (pending) is granted next.
- RST asserted low during beat 4 of a burst:
  - Expected: all outputs go to reset values immediately; after release with requesters 0 and 1 both pending, requester 0 is granted first (rr_ptr=0).
- ARB_FIXED_PRIO_EN defined, both requesters continuously pending:
  - Expected: requester 0 wins every burst boundary; requester 1 is never granted.
